// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
// Pattern and length fields are sized for the widest legal detector.
package seq_detect_pkg;

    localparam int MAX_LEN_MIN = 2;
    localparam int MAX_LEN_MAX = 32;
    localparam int CFG_LEN_W   = 6;

    typedef struct packed {
        logic [MAX_LEN_MAX-1:0] pattern;
        logic [CFG_LEN_W-1:0]   len;
        logic                   overlap;
    } seq_cfg_t;

    function automatic logic [MAX_LEN_MAX-1:0] len_mask(input logic [CFG_LEN_W-1:0] len);
        logic [MAX_LEN_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN_MAX; i++) begin
            if (i < int'(len)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable Mealy bit-sequence detector with overlap control,
// input qualification and a saturating match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               x_valid,
    input  logic               x,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    input  logic               cnt_clr
);

    seq_cfg_t               cfg_q;
    // The oldest history bit can never take part in a match (the live bit
    // fills the last slot), so only MAX_LEN-1 bits are stored.
    logic [MAX_LEN-2:0]     hist;
    logic [LEN_W-1:0]       fill;
    logic                   x_bit;
    logic                   valid;
    logic [MAX_LEN-1:0]     window;
    logic [CFG_LEN_W-1:0]   len_in;
    logic                   fill_ok;
    logic                   pat_ok;
    logic                   match;

    assign x_bit   = (x === 1'b1);
    assign valid   = (x_valid === 1'b1);
    assign window  = {hist, x_bit};
    assign len_in  = (cfg_len > LEN_W'(MAX_LEN)) ? CFG_LEN_W'(MAX_LEN) : CFG_LEN_W'(cfg_len);
    assign fill_ok = (int'(fill) + 1) >= int'(cfg_q.len);
    assign pat_ok  = (((MAX_LEN_MAX'(window)) ^ cfg_q.pattern) & len_mask(cfg_q.len)) == '0;
    assign match   = !rst && !cfg_load && valid && (cfg_q.len != '0) && fill_ok && pat_ok;
    assign z       = match;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q.pattern <= '0;
            cfg_q.len     <= '0;
            cfg_q.overlap <= 1'b1;
            hist          <= '0;
            fill          <= '0;
        end else if (cfg_load) begin
            cfg_q.pattern <= MAX_LEN_MAX'(cfg_pattern);
            cfg_q.len     <= len_in;
            cfg_q.overlap <= cfg_overlap;
            hist          <= '0;
            fill          <= '0;
        end else if (valid) begin
            hist <= window[MAX_LEN-2:0];
            if (match && !cfg_q.overlap) begin
                fill <= '0;
            end else if (fill != LEN_W'(MAX_LEN)) begin
                fill <= fill + LEN_W'(1);
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match),
        .clr   (cnt_clr),
        .count (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: queue-based reference model checked every
// cycle on two instances (8-bit and 2-bit counters), plus literal pins.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst, cfg_load, cfg_overlap, x_valid, x, cnt_clr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       z, z2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    always #5 clk = ~clk;

    seq_detect_param #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x_valid(x_valid), .x(x),
        .z(z), .match_cnt(match_cnt), .cnt_clr(cnt_clr)
    );

    seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x_valid(x_valid), .x(x),
        .z(z2), .match_cnt(match_cnt2), .cnt_clr(cnt_clr)
    );

    int   vectors = 0;
    int   ncmp = 0;
    int   errors = 0;
    logic m_q[$];
    int   m_len = 0;
    logic [31:0] m_pat = '0;
    logic m_ovl = 1'b1;
    int   m_cnt8 = 0;
    int   m_cnt2 = 0;
    logic cnt_known = 1'b0;
    logic last_z;

    task automatic check(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Matches when the last len accepted bits (oldest first) plus the live bit
    // spell the pattern, MSB first.
    function automatic logic model_z();
        logic ok;
        logic b;
        if (rst || cfg_load || !x_valid || m_len == 0) return 1'b0;
        if (m_q.size() + 1 < m_len) return 1'b0;
        ok = 1'b1;
        for (int j = 0; j < m_len; j++) begin
            b = (j == 0) ? x : m_q[m_q.size() - j];
            if (b != m_pat[j]) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic model_update(input logic m);
        if (rst) begin
            m_q.delete(); m_len = 0; m_pat = '0; m_ovl = 1'b1;
            m_cnt8 = 0; m_cnt2 = 0; cnt_known = 1'b1;
            return;
        end
        if (cnt_clr) begin
            m_cnt8 = 0; m_cnt2 = 0;
        end else if (m) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        if (cfg_load) begin
            m_q.delete();
            m_len = (cfg_len > 8) ? 8 : int'(cfg_len);
            m_pat = {24'h0, cfg_pattern};
            m_ovl = cfg_overlap;
        end else if (x_valid) begin
            if (m && !m_ovl) begin
                m_q.delete();
            end else begin
                m_q.push_back(x);
                if (m_q.size() > 8) void'(m_q.pop_front());
            end
        end
    endtask

    task automatic tick(input logic r, input logic l, input logic [7:0] p, input logic [3:0] ln,
                        input logic ov, input logic v, input logic xb, input logic cc);
        logic ez;
        @(negedge clk);
        rst = r; cfg_load = l; cfg_pattern = p; cfg_len = ln; cfg_overlap = ov;
        x_valid = v; x = xb; cnt_clr = cc;
        #1;
        vectors++;
        ez = model_z();
        check("z", int'(z), int'(ez));
        check("z_cnt2", int'(z2), int'(ez));
        if (cnt_known) begin
            check("match_cnt", int'(match_cnt), m_cnt8);
            check("match_cnt_w2", int'(match_cnt2), m_cnt2);
        end
        last_z = z;
        model_update(ez);
    endtask

    task automatic bit_in(input logic b);
        tick(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic idle(input logic cc);
        tick(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, cc);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] ln, input logic ov);
        tick(1'b0, 1'b1, p, ln, ov, 1'b0, 1'b0, 1'b1);
    endtask

    // Sends n bits MSB-first from bits; zv reads in stream order (MSB = first bit).
    task automatic stream(input logic [15:0] bits, input int n, output logic [15:0] zv);
        zv = '0;
        for (int i = n - 1; i >= 0; i--) begin
            bit_in(bits[i]);
            zv[i] = last_z;
        end
    endtask

    logic [15:0] zv;
    int zcount;

    initial begin
        rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        x_valid = 1'b0; x = 1'b0; cnt_clr = 1'b0;

        tick(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        check("reset_cnt", int'(match_cnt), 0);
        check("reset_z", int'(z), 0);
        bit_in(1'b0);
        check("unconfigured_z", int'(z), 0);

        load(8'b1010, 4'd4, 1'b1);
        stream(16'b101010, 6, zv);
        check("ovl_1010_z", int'(zv[5:0]), 6'b000101);
        idle(1'b0);
        check("ovl_1010_cnt", int'(match_cnt), 2);

        load(8'b1010, 4'd4, 1'b0);
        stream(16'b101010, 6, zv);
        check("novl_1010_z", int'(zv[5:0]), 6'b000100);
        idle(1'b0);
        check("novl_1010_cnt", int'(match_cnt), 1);

        load(8'b1011, 4'd4, 1'b1);
        stream(16'b1011011, 7, zv);
        check("ovl_1011_z", int'(zv[6:0]), 7'b0001001);

        load(8'hA5, 4'd8, 1'b1);
        zcount = 0;
        for (int i = 7; i >= 3; i--) begin bit_in(8'hA5 >> i); zcount += int'(last_z); end
        for (int i = 0; i < 3; i++) begin idle(1'b0); zcount += int'(last_z); end
        for (int i = 2; i >= 1; i--) begin bit_in(8'hA5 >> i); zcount += int'(last_z); end
        check("gap_no_early_z", zcount, 0);
        bit_in(1'b1);
        check("gap_final_z", int'(last_z), 1);
        idle(1'b0);
        check("gap_cnt", int'(match_cnt), 1);

        load(8'b1010, 4'd4, 1'b1);
        stream(16'b101, 3, zv);
        tick(1'b0, 1'b1, 8'b1010, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        check("load_suppress_z", int'(last_z), 0);
        stream(16'b1010, 4, zv);
        check("after_load_z", int'(zv[3:0]), 4'b0001);
        idle(1'b0);
        check("after_load_cnt", int'(match_cnt), 1);

        load(8'b10, 4'd2, 1'b1);
        stream(16'b1010101010, 10, zv);
        idle(1'b0);
        check("sat_cnt_w2", int'(match_cnt2), 3);
        check("sat_cnt_w8", int'(match_cnt), 5);
        bit_in(1'b1);
        tick(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("clr_with_match_z", int'(last_z), 1);
        idle(1'b0);
        check("clr_beats_inc", int'(match_cnt), 0);

        load(8'hFF, 4'd12, 1'b1);
        for (int i = 0; i < 8; i++) bit_in(1'b1);
        check("clamp_len_z", int'(last_z), 1);

        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 3) begin
                tick(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            end else if (r < 30) begin
                tick(1'b0, 1'b1, 8'($urandom), ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                     : 4'($urandom_range(1, 4)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));
            end else begin
                tick(1'b0, 1'b0, 8'($urandom), 4'($urandom), 1'($urandom),
                     ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 49) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised, runtime-programmable serial bit-sequence detector (Mealy) with selectable overlapping and non-overlapping modes, input qualification and a saturating match counter. It is the general-purpose successor to the team's fixed-pattern FSM detectors. It sits on any 1-bit serial stream, for example a protocol preamble or sync-word search, and raises `z` combinationally in the cycle the final pattern bit arrives.

## Interface
Parameters:
- `MAX_LEN`, 8: maximum pattern length in bits; legal range 2..32.
- `CNT_W`, 8: width of the match counter.
- `LEN_W`, `$clog2(MAX_LEN+1)`: width of the length field. Derived; do not override.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_load`  in  1  one-cycle pulse; latches `cfg_pattern`, `cfg_len` and `cfg_overlap`, and clears the history.
- `cfg_pattern`  in  MAX_LEN  pattern, right-aligned. `cfg_pattern[len-1]` is the first bit received; `cfg_pattern[0]` is the last.
- `cfg_len`  in  LEN_W  pattern length, 1..MAX_LEN.
- `cfg_overlap`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `x_valid`  in  1  qualifies `x`; the stream advances only when it is high.
- `x`  in  1  serial data bit.
- `z`  out  1  Mealy match flag, combinational from state and `x`.
- `match_cnt`  out  CNT_W  saturating count of matches since reset or `cnt_clr`.
- `cnt_clr`  in  1  synchronous clear of `match_cnt`.

## Operation
- Configuration registers:
  - `pat_q`, `len_q`, `ovl_q`.
  - Reset values: pattern 0, length 0, overlap 1.
  - Length 0 is the unconfigured state. While `len_q` = 0, `z` is never asserted.
- Sequence state:
  - `hist` is a MAX_LEN-bit shift register; newest bit is in the LSB.
  - `fill` is a counter saturating at MAX_LEN: the number of valid bits accepted since the last clear.
- Accept rule, when `x_valid`=1:
  - `hist <= {hist[MAX_LEN-2:0], x}`.
  - `fill <= min(fill+1, MAX_LEN)`.
- Match condition, combinational:
  - All of the following must hold: `x_valid`=1, `len_q`≠0, `fill` ≥ `len_q`-1, and `{hist, x}` low `len_q` bits == `pat_q` low `len_q` bits.
  - Compare using a mask built from `len_q`; bits above `len_q` are ignored.
  - `z` = match condition.
- Overlap mode: after a match the history is retained, so the suffix of one match may begin the next.
- Non-overlap mode: on a match cycle, `fill <= 0`. The matching bit is not kept as history for the next search.
- `x` must be treated as 1 only when it is exactly 1'b1; `z` must never be X.
- `match_cnt`: +1 on each match cycle, saturating at 2^CNT_W-1.
- Priority of simultaneous events:
  1. `rst` clears everything.
  2. `cfg_load` clears `hist` and `fill` and loads config. A match in the same cycle is suppressed (`z`=0, not counted) and `x` is discarded.
  3. `cnt_clr` beats a same-cycle increment, so the count becomes 0.
- `cfg_len` > MAX_LEN at load is clamped to MAX_LEN.

## Timing
- Reset values:
  - `z`=0.
  - `match_cnt`=0.
  - `hist`=0, `fill`=0.
  - Config registers as listed in Operation.
- Latency:
  - `z` has zero cycles of latency: it asserts in the same cycle the final bit is presented with `x_valid`.
  - `match_cnt` reflects that match one cycle later.
- Gaps in `x_valid` do not break a sequence; state holds during the gap.
- New config applies to the first valid bit after the `cfg_load` cycle.
- Reset asserted mid-sequence discards all partial progress. The first post-reset match needs `len` fresh bits. Config must be reloaded after reset.

## Structure
- Shared package `seq_detect_pkg`:
  - `MAX_LEN` bounds.
  - Function `len_mask(len)` returning the MAX_LEN-bit compare mask.
  - Typedef `seq_cfg_t` struct {pattern, len, overlap}.
- One natural sub-module, `sat_counter`: parametrised width, with `inc` and `clr` inputs, saturating. It is reusable by other blocks.
- Everything else lives in `seq_detect_param`: config registers, history, fill, compare.

## Test plan
- Load 1010 (len 4), overlap=1, stream 1,0,1,0,1,0 with `x_valid`=1 → `z` high on bits 4 and 6; `match_cnt`=2.
- Same stream with overlap=0 → `z` high on bit 4 only; `match_cnt`=1.
- Load 1011 (len 4), overlap=1, stream 1,0,1,1,0,1,1 → `z` on bits 4 and 7.
- Load len 8 pattern 0xA5, stream 0xA5 MSB-first with `x_valid` low for 3 cycles between bits 5 and 6 → one match on bit 8; `z` is low during the gap.
- `cfg_load` asserted on the cycle the 4th bit of 1010 arrives → no `z`, count unchanged. The next full 1,0,1,0 matches.
- CNT_W=2 with 5 overlapping matches → count saturates at 3. `cnt_clr` asserted together with a match → count 0.
